unified_buffer_mc: RTL
======================

Name: unified_buffer_mc

Overview:
- Parametrised multi-lane successor of the TPU unified buffer: a DEPTH-entry scratch memory with a NUM_CH-lane packed write port and a NUM_CH-lane skewed read port that feeds the systolic array directly.
- Adds explicit write/read base addresses and a column (strided/transposed) read mode.
- Adds busy/done status and modulo-DEPTH address wrap.
- Sits between the host/activation write-back path and the systolic array input edge.

Parameters:
- DATA_W, 16, bit width of one memory word.
- DEPTH, 64, number of words; must be a power of two.
- NUM_CH, 2, number of write lanes and read lanes (≥1).
- ADDR_W, $clog2(DEPTH), address width (derived; do not override).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- wr_start_in  in  1  pulse: load write pointer from wr_addr_in
- wr_addr_in  in  ADDR_W  write base address
- wr_data_in  in  NUM_CH*DATA_W  lane c at bits [c*DATA_W +: DATA_W]
- wr_valid_in  in  NUM_CH  per-lane write valid
- rd_start_in  in  1  pulse: start read burst
- rd_addr_in  in  ADDR_W  read base address
- rd_len_in  in  ADDR_W+1  total words to read
- rd_col_in  in  1  0 = row mode, 1 = column mode
- rd_stride_in  in  ADDR_W  column-mode lane stride
- rd_data_out  out  NUM_CH*DATA_W  per-lane read data, registered
- rd_valid_out  out  NUM_CH  per-lane read valid, registered
- rd_busy_out  out  1  read burst in progress
- rd_done_out  out  1  one-cycle pulse at end of burst

Behaviour:
- Reset:
  - clk is the clock; reset rst is asynchronous, active-high.
  - All outputs, the memory, wr_ptr, the read counter, and latched read parameters are cleared to 0; FSM goes to IDLE.
  - Reset mid-burst aborts the burst; no rd_done_out is produced.
- Address arithmetic: all addresses are computed modulo DEPTH (wrap, no error).
- Write:
  - wr_start_in=1 sets wr_ptr to wr_addr_in for that cycle's writes.
  - Valid lanes are compacted in ascending lane order: the k-th valid lane writes mem[wr_ptr+k].
  - wr_ptr advances by popcount(wr_valid_in).
  - Writes occur independently of the read FSM.
- Read FSM states:
  - IDLE: rd_start_in=1 and rd_len_in≠0 → latch base, L, mode, stride; t←0; go to ACTIVE. rd_start_in with rd_len_in=0 is ignored.
  - ACTIVE: rd_busy_out=1; t increments each cycle. When t = B+NUM_CH-2, with B = ceil(L/NUM_CH), go to IDLE.
  - rd_start_in received while ACTIVE is ignored.
- Skew:
  - For cycle index t, lane c reads beat b = t−c.
  - Lane c is valid iff 0 ≤ b < B and b*NUM_CH+c < L.
  - Row mode address: base + b*NUM_CH + c. Column mode address: base + c*stride + b.
  - Lanes that are not valid output data 0 and valid 0.
- Timing:
  - rd_start_in accepted at cycle 0 → output for t appears at cycle t+1.
  - Lane c beat b appears at cycle 1+b+c.
  - rd_done_out pulses at cycle B+NUM_CH−1, the last skew-window cycle, even if no lane is valid then.
  - rd_busy_out is high from cycle 1 through cycle B+NUM_CH−1. A new rd_start_in is accepted in the cycle after that window ends.
- Read/write collision on the same address in the same cycle: the read returns the old data.

Test Plan:
- Reset, NUM_CH=2, DEPTH=64: all outputs 0; a row read of base 0, L=2 returns 0,0.
- Write start at addr 0, both lanes valid for 3 cycles with (1,2),(3,4),(5,6) → mem[0..5]=1..6 and wr_ptr=6. Then a single cycle with only lane1 valid, data 7 → mem[6]=7.
- Row read, base 0, L=6 (started cycle 0):
  - lane0 = 1,3,5 at cycles 1–3; lane1 = 2,4,6 at cycles 2–4.
  - rd_done_out at cycle 4; busy over cycles 1–4.
- Row read, L=5: lane0 = 1,3,5 at cycles 1–3; lane1 = 2,4 at cycles 2–3; lane1 valid=0 at cycle 4; rd_done_out at cycle 4.
- Column read, base 0, stride 3, L=4:
  - lane0 = 1,2 at cycles 1–2; lane1 = 4,5 at cycles 2–3; done at cycle 3.
  - A second rd_start_in at cycle 2 is ignored.
- Wrap and abort:
  - Write start at addr 63 with (8,9) → mem[63]=8, mem[0]=9, wr_ptr=1.
  - Row read base 63, L=2 returns lane0=8 at cycle 1, lane1=9 at cycle 2.
  - Asserting rst at cycle 1 instead clears outputs immediately; no rd_done_out follows.

Source files
------------

// File: rtl/unified_buffer_mc.sv
// rtl/unified_buffer_mc.sv - multi-lane scratch buffer with compacting write port and skewed row/column read port
module unified_buffer_mc #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 64,
    parameter int NUM_CH = 2,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_start_in,
    input  logic [ADDR_W-1:0]        wr_addr_in,
    input  logic [NUM_CH*DATA_W-1:0] wr_data_in,
    input  logic [NUM_CH-1:0]        wr_valid_in,
    input  logic                     rd_start_in,
    input  logic [ADDR_W-1:0]        rd_addr_in,
    input  logic [ADDR_W:0]          rd_len_in,
    input  logic                     rd_col_in,
    input  logic [ADDR_W-1:0]        rd_stride_in,
    output logic [NUM_CH*DATA_W-1:0] rd_data_out,
    output logic [NUM_CH-1:0]        rd_valid_out,
    output logic                     rd_busy_out,
    output logic                     rd_done_out
);

    // Wide enough for the longest skew window: ceil((2*DEPTH-1)/NUM_CH) + NUM_CH.
    localparam int CNT_W = $clog2(2 * DEPTH + NUM_CH) + 1;

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] wr_eff;
    logic [ADDR_W-1:0] wr_cnt;
    logic [ADDR_W-1:0] wr_lane_addr [NUM_CH];

    // Valid lanes are packed onto consecutive addresses in ascending lane order.
    always_comb begin
        wr_eff = wr_start_in ? wr_addr_in : wr_ptr;
        wr_cnt = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            wr_lane_addr[c] = wr_eff + wr_cnt;
            if (wr_valid_in[c]) begin
                wr_cnt = wr_cnt + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_valid_in[c]) begin
                    mem[wr_lane_addr[c]] <= wr_data_in[c*DATA_W +: DATA_W];
                end
            end
            wr_ptr <= wr_eff + wr_cnt;
        end
    end

    state_t            state;
    logic [CNT_W-1:0]  t;
    logic [ADDR_W-1:0] base_l;
    logic [ADDR_W:0]   len_l;
    logic              col_l;
    logic [ADDR_W-1:0] stride_l;

    logic                     accept;
    logic [CNT_W-1:0]         sel_t;
    logic [ADDR_W-1:0]        sel_base;
    logic [ADDR_W:0]          sel_len;
    logic                     sel_col;
    logic [ADDR_W-1:0]        sel_stride;
    int                       sel_beats;
    int                       sel_last;
    logic [NUM_CH*DATA_W-1:0] nxt_data;
    logic [NUM_CH-1:0]        nxt_valid;

    // Outputs are registered, so the lane view is computed for the t about to be shown:
    // t=0 from the live inputs on acceptance, otherwise t+1 from the latched burst.
    always_comb begin
        int b;
        logic [ADDR_W-1:0] ra;
        b      = 0;
        ra     = '0;
        accept = (state == IDLE) && rd_start_in && (rd_len_in != '0);
        if (state == IDLE) begin
            sel_t      = '0;
            sel_base   = rd_addr_in;
            sel_len    = rd_len_in;
            sel_col    = rd_col_in;
            sel_stride = rd_stride_in;
        end else begin
            sel_t      = t + CNT_W'(1);
            sel_base   = base_l;
            sel_len    = len_l;
            sel_col    = col_l;
            sel_stride = stride_l;
        end
        sel_beats = (int'(sel_len) + NUM_CH - 1) / NUM_CH;
        sel_last  = sel_beats + NUM_CH - 2;
        nxt_data  = '0;
        nxt_valid = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            b  = int'(sel_t) - c;
            ra = sel_col ? sel_base + ADDR_W'(c * int'(sel_stride)) + ADDR_W'(b)
                         : sel_base + ADDR_W'(b * NUM_CH + c);
            if (b >= 0 && b < sel_beats && (b * NUM_CH + c) < int'(sel_len)) begin
                nxt_valid[c]                  = 1'b1;
                nxt_data[c*DATA_W +: DATA_W] = mem[ra];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            t            <= '0;
            base_l       <= '0;
            len_l        <= '0;
            col_l        <= 1'b0;
            stride_l     <= '0;
            rd_data_out  <= '0;
            rd_valid_out <= '0;
            rd_busy_out  <= 1'b0;
            rd_done_out  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rd_done_out <= 1'b0;
                    if (accept) begin
                        state        <= ACTIVE;
                        t            <= '0;
                        base_l       <= rd_addr_in;
                        len_l        <= rd_len_in;
                        col_l        <= rd_col_in;
                        stride_l     <= rd_stride_in;
                        rd_data_out  <= nxt_data;
                        rd_valid_out <= nxt_valid;
                        rd_busy_out  <= 1'b1;
                        rd_done_out  <= (sel_last == 0);
                    end
                end
                ACTIVE: begin
                    if (int'(t) == sel_last) begin
                        state        <= IDLE;
                        rd_data_out  <= '0;
                        rd_valid_out <= '0;
                        rd_busy_out  <= 1'b0;
                        rd_done_out  <= 1'b0;
                    end else begin
                        t            <= sel_t;
                        rd_data_out  <= nxt_data;
                        rd_valid_out <= nxt_valid;
                        rd_done_out  <= (int'(sel_t) == sel_last);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
